// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Opcodes, FSM states and the registered control/flag bundles.
package alu_arbiter_pkg;

    localparam int REG_MSB = 31;

    localparam logic [2:0] ADD_ALU = 3'd0;
    localparam logic [2:0] SUB_ALU = 3'd1;
    localparam logic [2:0] OR_ALU  = 3'd2;
    localparam logic [2:0] AND_ALU = 3'd3;
    localparam logic [2:0] NOT_ALU = 3'd4;
    localparam logic [2:0] XOR_ALU = 3'd5;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic       port;
        logic [2:0] operation;
    } op_ctl_t;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= XOR_ALU;
    endfunction

    // Only arithmetic ops produce meaningful carry/overflow.
    function automatic logic op_arith(input logic [2:0] op);
        return (op == ADD_ALU) || (op == SUB_ALU);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Per-port request/response channel between a requester and the arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int REG_W = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [REG_W-1:0] req_op1;
    logic [REG_W-1:0] req_op2;
    logic [2:0]       req_operation;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [REG_W-1:0] rsp_res;
    logic [3:0]       rsp_flags;
    logic             rsp_err;

    modport master (
        output req_valid,
        output req_op1,
        output req_op2,
        output req_operation,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_res,
        input  rsp_flags,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_op1,
        input  req_op2,
        input  req_operation,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_res,
        output rsp_flags,
        output rsp_err
    );

endinterface

// File: rtl/alu_rr_pick.sv
// Two-way round-robin picker; on a tie the port that did not win last time
// is chosen. Purely combinational.
module alu_rr_pick (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = |valid;
        grant = ~last_grant;
        unique case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = ~last_grant;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grants.
// Operands are registered before the ALU and results after it; one op in flight.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int REG_W = REG_MSB + 1
) (
    input  logic             clk,
    input  logic             reset,

    alu_arbiter_if.slave     p0,
    alu_arbiter_if.slave     p1,

    output logic [REG_W-1:0] alu_op1,
    output logic [REG_W-1:0] alu_op2,
    output logic [2:0]       alu_operation,
    output logic             alu_enable,
    output logic             alu_reset,
    input  logic [REG_W-1:0] alu_res,
    input  logic             alu_C,
    input  logic             alu_Z,
    input  logic             alu_N,
    input  logic             alu_V
);

    arb_state_e       state;
    arb_state_e       state_nx;
    logic             last_grant;

    logic [REG_W-1:0] op1_q;
    logic [REG_W-1:0] op2_q;
    op_ctl_t          ctl_q;

    logic [REG_W-1:0] res_q;
    flags_t           flags_q;
    logic             err_q;

    logic             grant;
    logic             any;
    logic             accept;
    logic             done;
    logic             legal;
    logic             arith;
    logic             rsp_rdy_sel;
    logic [1:0]       rsp_v;

    alu_rr_pick u_pick (
        .valid      ({p1.req_valid, p0.req_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .any        (any)
    );

    assign legal       = op_legal(ctl_q.operation);
    assign arith       = op_arith(ctl_q.operation);
    assign rsp_rdy_sel = ctl_q.port ? p1.rsp_ready : p0.rsp_ready;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        done     = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (any) begin
                    accept   = 1'b1;
                    state_nx = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                state_nx = ARB_RESP;
            end
            ARB_RESP: begin
                if (rsp_rdy_sel) begin
                    done     = 1'b1;
                    state_nx = ARB_IDLE;
                end
            end
            default: begin
                state_nx = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
            op1_q      <= '0;
            op2_q      <= '0;
            ctl_q      <= '0;
            res_q      <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op1_q           <= grant ? p1.req_op1 : p0.req_op1;
                op2_q           <= grant ? p1.req_op2 : p0.req_op2;
                ctl_q.port      <= grant;
                ctl_q.operation <= grant ? p1.req_operation
                                         : p0.req_operation;
            end
            // Stale carry/overflow from the ALU is masked for logic ops.
            if (state == ARB_EXEC) begin
                if (legal) begin
                    res_q     <= alu_res;
                    flags_q.c <= arith & alu_C;
                    flags_q.z <= alu_Z;
                    flags_q.n <= alu_N;
                    flags_q.v <= arith & alu_V;
                    err_q     <= 1'b0;
                end else begin
                    res_q   <= '0;
                    flags_q <= '0;
                    err_q   <= 1'b1;
                end
            end
            if (done) begin
                last_grant <= ctl_q.port;
            end
        end
    end

    assign rsp_v[0] = (state == ARB_RESP) & ~ctl_q.port;
    assign rsp_v[1] = (state == ARB_RESP) &  ctl_q.port;

    assign p0.req_ready = (state == ARB_IDLE) & ~reset & ~grant;
    assign p1.req_ready = (state == ARB_IDLE) & ~reset &  grant;

    assign p0.rsp_valid = rsp_v[0];
    assign p0.rsp_res   = rsp_v[0] ? res_q : '0;
    assign p0.rsp_flags = rsp_v[0] ? flags_q : 4'b0000;
    assign p0.rsp_err   = rsp_v[0] & err_q;

    assign p1.rsp_valid = rsp_v[1];
    assign p1.rsp_res   = rsp_v[1] ? res_q : '0;
    assign p1.rsp_flags = rsp_v[1] ? flags_q : 4'b0000;
    assign p1.rsp_err   = rsp_v[1] & err_q;

    assign alu_op1       = op1_q;
    assign alu_op2       = op2_q;
    assign alu_operation = ctl_q.operation;
    assign alu_enable    = (state == ARB_EXEC) & legal;
    assign alu_reset     = reset;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic on both ports,
// checked against an arithmetic reference model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.REG_W(W)) p0 ();
    alu_arbiter_if #(.REG_W(W)) p1 ();

    logic [W-1:0] alu_op1;
    logic [W-1:0] alu_op2;
    logic [2:0]   alu_operation;
    logic         alu_enable;
    logic         alu_reset;
    logic [W-1:0] alu_res;
    logic         alu_C;
    logic         alu_Z;
    logic         alu_N;
    logic         alu_V;

    alu_arbiter #(.REG_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .p0            (p0),
        .p1            (p1),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_operation (alu_operation),
        .alu_enable    (alu_enable),
        .alu_reset     (alu_reset),
        .alu_res       (alu_res),
        .alu_C         (alu_C),
        .alu_Z         (alu_Z),
        .alu_N         (alu_N),
        .alu_V         (alu_V)
    );

    // Environment ALU: C/V are sticky from the last arithmetic op.
    logic [W:0] s;
    logic       hold_c;
    logic       hold_v;

    always_comb begin
        s       = '0;
        alu_res = '0;
        alu_C   = hold_c;
        alu_V   = hold_v;
        case (alu_operation)
            3'd0: begin
                s       = {1'b0, alu_op1} + {1'b0, alu_op2};
                alu_res = s[W-1:0];
                alu_C   = s[W];
                alu_V   = (alu_op1[W-1] == alu_op2[W-1]) &&
                          (alu_res[W-1] != alu_op1[W-1]);
            end
            3'd1: begin
                alu_res = alu_op1 - alu_op2;
                alu_C   = alu_op1 < alu_op2;
                alu_V   = (alu_op1[W-1] != alu_op2[W-1]) &&
                          (alu_res[W-1] != alu_op1[W-1]);
            end
            3'd2: alu_res = alu_op1 | alu_op2;
            3'd3: alu_res = alu_op1 & alu_op2;
            3'd4: alu_res = ~alu_op1;
            3'd5: alu_res = alu_op1 ^ alu_op2;
            default: alu_res = '0;
        endcase
        alu_Z = (alu_res == '0);
        alu_N = alu_res[W-1];
    end

    always @(posedge clk) begin
        if (alu_reset) begin
            hold_c <= 1'b0;
            hold_v <= 1'b0;
        end else if (alu_enable && alu_operation < 3'd2) begin
            hold_c <= alu_C;
            hold_v <= alu_V;
        end
    end

    int en_cnt = 0;
    always @(posedge clk) if (alu_enable) en_cnt <= en_cnt + 1;

    logic [1:0]   rv;
    logic [1:0]   rr;
    logic [W-1:0] ra [2];
    logic [W-1:0] rb [2];
    logic [2:0]   ro [2];
    logic [1:0]   rdy;
    logic [1:0]   rspv;
    logic [W-1:0] rres [2];
    logic [3:0]   rflg [2];
    logic [1:0]   rerr;

    assign p0.req_valid     = rv[0];
    assign p0.req_op1       = ra[0];
    assign p0.req_op2       = rb[0];
    assign p0.req_operation = ro[0];
    assign p0.rsp_ready     = rr[0];
    assign p1.req_valid     = rv[1];
    assign p1.req_op1       = ra[1];
    assign p1.req_op2       = rb[1];
    assign p1.req_operation = ro[1];
    assign p1.rsp_ready     = rr[1];

    assign rdy[0]  = p0.req_ready;
    assign rdy[1]  = p1.req_ready;
    assign rspv[0] = p0.rsp_valid;
    assign rspv[1] = p1.rsp_valid;
    assign rres[0] = p0.rsp_res;
    assign rres[1] = p1.rsp_res;
    assign rflg[0] = p0.rsp_flags;
    assign rflg[1] = p1.rsp_flags;
    assign rerr[0] = p0.rsp_err;
    assign rerr[1] = p1.rsp_err;

    int passed = 0;
    int total = 0;
    int fails = 0;
    int cyc = 0;
    int last_served = 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    // Reference: unbounded integer arithmetic, range checks for overflow.
    function automatic void model(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] res,
                                  output logic [3:0] flg,
                                  output logic err);
        longint ua, ub, sa, sb, r, t;
        longint lim;
        bit c, v;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        lim = 2147483647;
        c = 0; v = 0; err = 0; r = 0;
        case (op)
            3'd0: begin
                r = ua + ub; c = (r > 64'sd4294967295);
                t = sa + sb; v = (t > lim) || (t < -lim - 1);
            end
            3'd1: begin
                r = ua - ub; c = (ua < ub);
                t = sa - sb; v = (t > lim) || (t < -lim - 1);
            end
            3'd2: r = ua | ub;
            3'd3: r = ua & ub;
            3'd4: r = ~ua;
            3'd5: r = ua ^ ub;
            default: err = 1;
        endcase
        res = err ? 32'h0 : r[31:0];
        flg = err ? 4'b0000 : {c, res == 32'h0, res[31], v};
    endfunction

    function automatic logic [31:0] pick_val();
        logic [31:0] corners [5];
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic new_req(input int p);
        rv[p] = 1'b1;
        ro[p] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7))
                                            : 3'($urandom_range(0, 5));
        ra[p] = pick_val();
        rb[p] = pick_val();
    endtask

    task automatic set_req(input int p, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        rv[p] = 1'b1;
        ro[p] = op;
        ra[p] = a;
        rb[p] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_served = 1;
    endtask

    // Serves one operation: accept, EXEC, response (held `hold` cycles).
    task automatic serve(input bit reload, input int hold,
                         output int g, output int acc, output int rsp);
        int n, eg;
        logic [31:0] er;
        logic [3:0]  ef;
        logic        ee;
        g = 0; acc = cyc; rsp = cyc;
        #1;
        n = 0;
        while (!((rdy[0] && rv[0]) || (rdy[1] && rv[1])) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++; fails++;
            $error("FAIL accept_timeout observed=%0d expected=<50", n);
            return;
        end
        eg = (rv[0] && rv[1]) ? 1 - last_served : (rv[0] ? 0 : 1);
        g = (rdy[1] && rv[1]) ? 1 : 0;
        acc = cyc;
        chk("grant", 64'(g), 64'(eg));
        chk("other_ready", 64'(rdy[1-g]), 64'd0);
        model(ro[g], ra[g], rb[g], er, ef, ee);
        rr[g] = (hold == 0);
        tick();
        chk("exec_enable", 64'(alu_enable), 64'(!ee));
        chk("exec_op1", 64'(alu_op1), 64'(ra[g]));
        chk("exec_op2", 64'(alu_op2), 64'(rb[g]));
        if (reload) new_req(g);
        else rv[g] = 1'b0;
        n = 0;
        while (!rspv[g] && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++; fails++;
            $error("FAIL rsp_timeout observed=%0d expected=<50", n);
            return;
        end
        chk("latency", 64'(cyc - acc), 64'd2);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 64'(rspv[g]), 64'd1);
            chk("hold_res", 64'(rres[g]), 64'(er));
            tick();
        end
        rr[g] = 1'b1;
        rsp = cyc;
        chk("rsp_res", 64'(rres[g]), 64'(er));
        chk("rsp_flags", 64'(rflg[g]), 64'(ef));
        chk("rsp_err", 64'(rerr[g]), 64'(ee));
        chk("rsp_other_valid", 64'(rspv[1-g]), 64'd0);
        chk("rsp_other_res", 64'(rres[1-g]), 64'd0);
        tick();
        last_served = g;
        chk("rsp_drop", 64'(rspv[g]), 64'd0);
    endtask

    initial begin
        int g, acc, rsp, pacc, prsp, en0, n;
        rv = '0;
        rr = 2'b11;
        for (int p = 0; p < 2; p++) begin
            ra[p] = '0; rb[p] = '0; ro[p] = '0;
        end

        // Reset state.
        tick();
        chk("rst_ready0", 64'(rdy[0]), 64'd0);
        chk("rst_ready1", 64'(rdy[1]), 64'd0);
        chk("rst_rspv", 64'(rspv), 64'd0);
        chk("rst_enable", 64'(alu_enable), 64'd0);
        chk("rst_op1", 64'(alu_op1), 64'd0);
        chk("rst_operation", 64'(alu_operation), 64'd0);
        chk("rst_res0", 64'(rres[0]), 64'd0);
        chk("rst_flags0", 64'(rflg[0]), 64'd0);
        chk("rst_err", 64'(rerr), 64'd0);
        chk("rst_alu_reset", 64'(alu_reset), 64'd1);
        reset = 1'b0;
        last_served = 1;
        tick();

        // ADD overflow on port 0.
        set_req(0, ADD_ALU, 32'h7FFF_FFFF, 32'h0000_0001);
        serve(0, 0, g, acc, rsp);

        // Tie from reset: port 0 first, port 1 one cycle after handshake.
        do_reset();
        set_req(0, SUB_ALU, 32'd5, 32'd5);
        set_req(1, OR_ALU, 32'hF0, 32'h0F);
        serve(0, 0, g, acc, prsp);
        serve(0, 0, g, acc, rsp);
        chk("p1_after_p0", 64'(acc - prsp), 64'd1);

        // Continuous contention: alternating grants at 3-cycle spacing.
        do_reset();
        new_req(0);
        new_req(1);
        pacc = 0;
        for (int i = 0; i < 6; i++) begin
            serve(1, 0, g, acc, rsp);
            chk("rr_alternate", 64'(g), 64'(i % 2));
            if (i > 0) chk("throughput", 64'(acc - pacc), 64'd3);
            pacc = acc;
        end

        // Carry from SUB must not leak into a following logic op.
        do_reset();
        rv = '0;
        set_req(1, SUB_ALU, 32'h0, 32'h1);
        serve(0, 0, g, acc, rsp);
        set_req(1, AND_ALU, 32'hFFFF_FFFF, 32'h1);
        serve(0, 0, g, acc, rsp);

        // Illegal opcode.
        en0 = en_cnt;
        set_req(0, 3'd7, 32'h1234, 32'h5678);
        serve(0, 0, g, acc, rsp);
        chk("illegal_no_enable", 64'(en_cnt - en0), 64'd0);

        // Response held, then reset mid-RESP.
        set_req(0, ADD_ALU, 32'd3, 32'd4);
        n = 0;
        while (!rdy[0] && n < 20) begin
            tick();
            n++;
        end
        chk("hold_accept", 64'(rdy[0]), 64'd1);
        rr[0] = 1'b0;
        tick();
        rv[0] = 1'b0;
        set_req(1, OR_ALU, 32'h1, 32'h2);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("held_valid", 64'(rspv[0]), 64'd1);
            chk("held_res", 64'(rres[0]), 64'd7);
            chk("held_p1_ready", 64'(rdy[1]), 64'd0);
            tick();
        end
        reset = 1'b1;
        tick();
        chk("rst_mid_rspv", 64'(rspv), 64'd0);
        chk("rst_mid_ready", 64'(rdy), 64'd0);
        reset = 1'b0;
        rr[0] = 1'b1;
        last_served = 1;
        set_req(0, XOR_ALU, 32'hAAAA_5555, 32'hFFFF_0000);
        serve(0, 0, g, acc, rsp);
        chk("post_reset_tie", 64'(g), 64'd0);
        serve(0, 0, g, acc, rsp);

        // Random traffic with random response back-pressure.
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++)
                if (!rv[p] && $urandom_range(0, 1) == 1) new_req(p);
            if (rv == 2'b00) new_req(int'($urandom_range(0, 1)));
            serve(0, int'($urandom_range(0, 3)), g, acc, rsp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
